// File: rtl/seg_scan_driver.sv
//------------------------------------------------------------------------------
// seg_scan_driver: multiplexed seven-segment scan driver, double-buffered.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module seg_scan_driver #(
  parameter int N_DIGITS       = 8,
  parameter int SCAN_DIV       = 4,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          load,
  input  logic [8*N_DIGITS-1:0]         data_in,
  input  logic                          mode_in,
  input  logic [N_DIGITS-1:0]           blank_in,
  input  logic [N_DIGITS-1:0]           dp_in,
  output logic [7:0]                    seg,
  output logic [N_DIGITS-1:0]           an,
  output logic [$clog2(N_DIGITS)-1:0]   scan_idx,
  output logic                          frame_done
);

  localparam int IDX_W = $clog2(N_DIGITS);
  localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  localparam logic [PRE_W-1:0]    C_PRE_LAST = PRE_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0]    C_IDX_LAST = IDX_W'(N_DIGITS - 1);
  localparam logic [7:0]          C_SEG_OFF  = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
  localparam logic [N_DIGITS-1:0] C_AN_OFF   = SEG_ACTIVE_LOW ? '1 : '0;

  logic [PRE_W-1:0]      r_presc;
  logic [8*N_DIGITS-1:0] r_pend_data, r_act_data;
  logic                  r_pend_mode, r_act_mode;
  logic [N_DIGITS-1:0]   r_pend_blank, r_act_blank;
  logic [N_DIGITS-1:0]   r_pend_dp, r_act_dp;

  logic                  w_tick;
  logic                  w_wrap;
  logic [7:0]            w_byte;
  logic [3:0]            w_nib;
  logic [6:0]            w_dec;
  logic [7:0]            w_pattern;
  logic [N_DIGITS-1:0]   w_an;

  assign w_tick = (r_presc == C_PRE_LAST);
  assign w_wrap = w_tick && (scan_idx == C_IDX_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc    <= '0;
      scan_idx   <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= w_wrap;
      if (w_tick) begin
        r_presc  <= '0;
        scan_idx <= w_wrap ? '0 : scan_idx + 1'b1;
      end else begin
        r_presc  <= r_presc + 1'b1;
      end
    end
  end

  // A load coinciding with the frame boundary bypasses straight into the
  // active buffer so it is shown from digit 0 of the new frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend_data  <= '0;
      r_pend_mode  <= 1'b0;
      r_pend_blank <= '1;
      r_pend_dp    <= '0;
      r_act_data   <= '0;
      r_act_mode   <= 1'b0;
      r_act_blank  <= '1;
      r_act_dp     <= '0;
    end else begin
      if (load) begin
        r_pend_data  <= data_in;
        r_pend_mode  <= mode_in;
        r_pend_blank <= blank_in;
        r_pend_dp    <= dp_in;
      end
      if (w_wrap) begin
        r_act_data  <= load ? data_in  : r_pend_data;
        r_act_mode  <= load ? mode_in  : r_pend_mode;
        r_act_blank <= load ? blank_in : r_pend_blank;
        r_act_dp    <= load ? dp_in    : r_pend_dp;
      end
    end
  end

  assign w_byte = r_act_data[{scan_idx, 3'b000} +: 8];
  assign w_nib  = r_act_data[{scan_idx, 2'b00} +: 4];

  always_comb begin
    w_dec = 7'h00;
    case (w_nib)
      4'h0: w_dec = 7'h3F;
      4'h1: w_dec = 7'h06;
      4'h2: w_dec = 7'h5B;
      4'h3: w_dec = 7'h4F;
      4'h4: w_dec = 7'h66;
      4'h5: w_dec = 7'h6D;
      4'h6: w_dec = 7'h7D;
      4'h7: w_dec = 7'h07;
      4'h8: w_dec = 7'h7F;
      4'h9: w_dec = 7'h6F;
      4'hA: w_dec = 7'h77;
      4'hB: w_dec = 7'h7C;
      4'hC: w_dec = 7'h39;
      4'hD: w_dec = 7'h5E;
      4'hE: w_dec = 7'h79;
      4'hF: w_dec = 7'h71;
      default: w_dec = 7'h00;
    endcase
  end

  always_comb begin
    w_pattern = 8'h00;
    if (!r_act_blank[scan_idx]) begin
      w_pattern = r_act_mode ? w_byte : {r_act_dp[scan_idx], w_dec};
    end
  end

  assign w_an = N_DIGITS'(1) << scan_idx;

  // Anode stays enabled on blanked digits; only the segments go dark.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg <= C_SEG_OFF;
      an  <= C_AN_OFF;
    end else begin
      seg <= SEG_ACTIVE_LOW ? ~w_pattern : w_pattern;
      an  <= SEG_ACTIVE_LOW ? ~w_an : w_an;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_seg_scan_driver.sv
//------------------------------------------------------------------------------
// tb_seg_scan_driver: directed self-checking bench, N_DIGITS=4, SCAN_DIV=2.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_seg_scan_driver;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load;
  logic [31:0] data_in;
  logic        mode_in;
  logic [3:0]  blank_in;
  logic [3:0]  dp_in;
  logic [7:0]  seg;
  logic [3:0]  an;
  logic [1:0]  scan_idx;
  logic        frame_done;

  int errors = 0;
  int checks = 0;

  seg_scan_driver #(
    .N_DIGITS      (N),
    .SCAN_DIV      (2),
    .SEG_ACTIVE_LOW(1'b1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .data_in   (data_in),
    .mode_in   (mode_in),
    .blank_in  (blank_in),
    .dp_in     (dp_in),
    .seg       (seg),
    .an        (an),
    .scan_idx  (scan_idx),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic wait_fd(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 24 && !ok; i++) begin
      @(negedge clk);
      if (frame_done === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic wait_an(input int d, output bit ok);
    logic [3:0] e;
    e  = ~(4'b0001 << d);
    ok = 1'b0;
    for (int i = 0; i < 16 && !ok; i++) begin
      @(negedge clk);
      if (an === e) ok = 1'b1;
    end
  endtask

  task automatic do_load(input logic [31:0] d, input logic m,
                         input logic [3:0] b, input logic [3:0] p);
    data_in  = d;
    mode_in  = m;
    blank_in = b;
    dp_in    = p;
    load     = 1'b1;
    @(negedge clk);
    load     = 1'b0;
  endtask

  task automatic test_reset();
    logic [1:0] ei;
    rst_n = 1'b0; load = 1'b0; data_in = '0; mode_in = 1'b0;
    blank_in = '0; dp_in = '0;
    repeat (3) @(negedge clk);
    checks++; if (seg !== 8'hFF) begin errors++; $display("FAIL reset_seg: got %h want FF", seg); end
    checks++; if (an !== 4'hF) begin errors++; $display("FAIL reset_an: got %h want F", an); end
    checks++; if (scan_idx !== 2'd0) begin errors++; $display("FAIL reset_idx: got %0d want 0", scan_idx); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_fd: got %b want 0", frame_done); end
    rst_n = 1'b1;
    for (int j = 1; j <= 16; j++) begin
      @(negedge clk);
      ei = 2'((j / 2) % 4);
      checks++; if (scan_idx !== ei) begin errors++; $display("FAIL scan_seq[%0d]: got %0d want %0d", j, scan_idx, ei); end
      checks++; if (frame_done !== (j % 8 == 0)) begin errors++; $display("FAIL fd_period[%0d]: got %b want %b", j, frame_done, (j % 8 == 0)); end
      checks++; if (seg !== 8'hFF) begin errors++; $display("FAIL blank_seg[%0d]: got %h want FF", j, seg); end
    end
  endtask

  task automatic test_hex_double_buffer();
    logic [7:0] exp [4] = '{8'hC0, 8'h08, 8'h80, 8'h8E};
    bit ok, fd, held;
    repeat (2) @(negedge clk);
    do_load(32'h0000_F8A0, 1'b0, 4'b0000, 4'b0010);
    held = 1'b1; fd = 1'b0;
    for (int i = 0; i < 24 && !fd; i++) begin
      if (seg !== 8'hFF) held = 1'b0;
      if (frame_done === 1'b1) fd = 1'b1;
      else @(negedge clk);
    end
    checks++; if (!held || !fd) begin errors++; $display("FAIL no_tearing: held=%b fd=%b want 1 1", held, fd); end
    for (int d = 0; d < 4; d++) begin
      wait_an(d, ok);
      checks++; if (!ok || seg !== exp[d]) begin errors++; $display("FAIL hex_digit%0d: seg=%h an=%h want seg=%h", d, seg, an, exp[d]); end
    end
  endtask

  task automatic test_graphic();
    logic [7:0] exp [4] = '{8'h7F, 8'hFB, 8'hFD, 8'hFE};
    bit ok;
    wait_fd(ok);
    do_load(32'h0102_0480, 1'b1, 4'b0000, 4'b1111);
    wait_fd(ok);
    checks++; if (!ok) begin errors++; $display("FAIL gfx_fd: frame_done not seen"); end
    for (int d = 0; d < 4; d++) begin
      wait_an(d, ok);
      checks++; if (!ok || seg !== exp[d]) begin errors++; $display("FAIL gfx_digit%0d: seg=%h an=%h want seg=%h", d, seg, an, exp[d]); end
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    wait_fd(ok);
    do_load(32'h0000_1111, 1'b0, 4'b0000, 4'b0000);
    do_load(32'h0000_2222, 1'b0, 4'b0000, 4'b0000);
    wait_fd(ok);
    for (int d = 0; d < 4; d++) begin
      wait_an(d, ok);
      checks++; if (!ok || seg !== 8'hA4) begin errors++; $display("FAIL last_wins_digit%0d: seg=%h an=%h want A4", d, seg, an); end
    end
  endtask

  task automatic test_wrap_load();
    bit ok;
    wait_fd(ok);
    repeat (7) @(negedge clk);
    do_load(32'h0000_4567, 1'b0, 4'b0000, 4'b0000);
    checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL wrap_align: frame_done=%b want 1", frame_done); end
    @(negedge clk);
    checks++; if (an !== 4'hE || seg !== 8'hF8) begin errors++; $display("FAIL bypass_digit0: seg=%h an=%h want F8 E", seg, an); end
    wait_fd(ok);
    wait_an(3, ok);
    checks++; if (!ok || seg !== 8'h99) begin errors++; $display("FAIL bypass_pending3: seg=%h an=%h want 99", seg, an); end
  endtask

  task automatic test_blank_and_reset();
    logic [7:0] exp [4] = '{8'hFF, 8'hB0, 8'hFF, 8'hF9};
    bit ok;
    wait_fd(ok);
    do_load(32'h0000_1234, 1'b0, 4'b0101, 4'b0000);
    wait_fd(ok);
    for (int d = 0; d < 4; d++) begin
      wait_an(d, ok);
      checks++; if (!ok || seg !== exp[d]) begin errors++; $display("FAIL blank_digit%0d: seg=%h an=%h want seg=%h", d, seg, an, exp[d]); end
    end
    wait_fd(ok);
    repeat (3) @(negedge clk);
    do_load(32'h0000_8888, 1'b0, 4'b0000, 4'b0000);
    rst_n = 1'b0;
    #1;
    checks++; if (seg !== 8'hFF || an !== 4'hF || scan_idx !== 2'd0 || frame_done !== 1'b0)
      begin errors++; $display("FAIL async_reset: seg=%h an=%h idx=%0d fd=%b want FF F 0 0", seg, an, scan_idx, frame_done); end
    @(negedge clk);
    rst_n = 1'b1;
    wait_fd(ok);
    for (int d = 0; d < 4; d++) begin
      wait_an(d, ok);
      checks++; if (!ok || seg !== 8'hFF) begin errors++; $display("FAIL pending_discard%0d: seg=%h an=%h want FF", d, seg, an); end
    end
  endtask

  initial begin
    test_reset();
    test_hex_double_buffer();
    test_graphic();
    test_back_to_back();
    test_wrap_load();
    test_blank_and_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
